caxi4interconnect_slv_mem_responder: RTL and testbench

CAXI4INTERCONNECT_SLV_MEM_RESPONDER -- requirements
Module: caxi4interconnect_slv_mem_responder

---
 rtl/caxi4interconnect_slv_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_caxi4interconnect_slv_mem_responder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caxi4interconnect_slv_mem_responder.sv
// AXI4 slave-end responder backed by a small register memory.
// Independent write (AW/W/B) and read (AR/R) state machines, INCR full-width bursts only.
module caxi4interconnect_slv_mem_responder #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int DEC_LSB = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic                  live;
    logic [IDX_W-1:0]      w_idx, r_idx, aw_idx, ar_idx;
    logic [7:0]            w_len, w_cnt, r_len, r_cnt;
    logic                  w_dec, w_err, r_dec;
    logic                  aw_dec, ar_dec;
    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  w_last_beat, r_last_beat, wlast_err;
    logic                  unused_addr;

    assign aw_idx      = AWADDR[IDX_LSB +: IDX_W];
    assign ar_idx      = ARADDR[IDX_LSB +: IDX_W];
    assign aw_dec      = |AWADDR[ADDR_WIDTH-1:DEC_LSB];
    assign ar_dec      = |ARADDR[ADDR_WIDTH-1:DEC_LSB];
    assign unused_addr = ^{AWADDR[IDX_LSB-1:0], ARADDR[IDX_LSB-1:0]};

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign ar_hs       = ARVALID && ARREADY;
    assign r_hs        = RVALID && RREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign r_last_beat = (r_cnt == r_len);
    assign wlast_err   = (WLAST != w_last_beat);

    // Holds both READY outputs low until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) live <= 1'b0;
        else          live <= 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next  = w_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = live;
                if (AWVALID && live) w_next = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = live;
                if (ARVALID && live) r_next = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = r_last_beat;
                if (RREADY && r_last_beat) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write burst bookkeeping; BRESP is fixed on the final beat and held through W_RESP.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            BID   <= '0;
            BRESP <= 2'b00;
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_dec <= 1'b0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            BID   <= AWID;
            w_idx <= aw_idx;
            w_len <= AWLEN;
            w_cnt <= '0;
            w_dec <= aw_dec;
            w_err <= 1'b0;
        end else if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            if (wlast_err) w_err <= 1'b1;
            if (w_last_beat) begin
                if (w_dec)                   BRESP <= 2'b11;
                else if (w_err || wlast_err) BRESP <= 2'b10;
                else                         BRESP <= 2'b00;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (w_hs && !w_dec) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // RDATA is loaded only on AR or R handshakes, so it samples pre-write memory and holds under stall.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            RID   <= '0;
            RDATA <= '0;
            RRESP <= 2'b00;
            r_idx <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_dec <= 1'b0;
        end else if (ar_hs) begin
            RID   <= ARID;
            RDATA <= ar_dec ? '0 : mem[ar_idx];
            RRESP <= ar_dec ? 2'b11 : 2'b00;
            r_idx <= ar_idx + 1'b1;
            r_len <= ARLEN;
            r_cnt <= '0;
            r_dec <= ar_dec;
        end else if (r_hs && !r_last_beat) begin
            RDATA <= r_dec ? '0 : mem[r_idx];
            r_idx <= r_idx + 1'b1;
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_caxi4interconnect_slv_mem_responder.sv
// Self-checking bench for caxi4interconnect_slv_mem_responder: directed scenarios plus
// randomized bursts checked against a word-array memory model.
module tb_caxi4interconnect_slv_mem_responder;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  AWID, BID, ARID, RID;
    logic [19:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    caxi4interconnect_slv_mem_responder #(
        .ID_WIDTH(1), .ADDR_WIDTH(20), .DATA_WIDTH(32), .MEM_DEPTH(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          gap_en   = 0;
    logic [31:0] model [16];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [0:0]  rd_id [256];
    logic [1:0]  b_resp;
    logic [0:0]  b_id;
    logic        b_first, aw_ready_after, r_first, ar_ready_after;

    // Reference model: 16 words, word = (addr/4) mod 16, any address >= 64 is undecoded.
    function automatic logic [1:0] model_write(input logic [19:0] addr, input int len);
        int  base = int'(addr) / 4;
        bit  dec  = (addr >= 20'd64);
        bit  mism = 0;
        for (int i = 0; i <= len; i++) begin
            if (wl[i] != (i == len)) mism = 1;
            if (!dec)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[(base + i) % 16][b*8 +: 8] = wd[i][b*8 +: 8];
        end
        return dec ? 2'b11 : (mism ? 2'b10 : 2'b00);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [19:0] addr, input int i);
        if (addr >= 20'd64) return 32'h0;
        return model[(int'(addr) / 4 + i) % 16];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [19:0] addr);
        return (addr >= 20'd64) ? 2'b11 : 2'b00;
    endfunction

    task automatic timeout(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL timeout %s: got no handshake, required one within 50 cycles", what);
    endtask

    task automatic axi_write(input logic [19:0] addr, input logic [7:0] len, input logic [0:0] id);
        int k;
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        k = 0;
        while (AWREADY !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
        if (k >= 50) begin timeout("aw"); AWVALID = 1'b0; return; end
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gap_en != 0 && $urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(negedge ACLK); end
            WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = wl[i];
            k = 0;
            while (WREADY !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
            if (k >= 50) begin timeout("w"); WVALID = 1'b0; return; end
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        b_first = BVALID;
        BREADY = 1'b1;
        k = 0;
        while (BVALID !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
        if (k >= 50) begin timeout("b"); BREADY = 1'b0; return; end
        b_resp = BRESP; b_id = BID;
        @(negedge ACLK);
        BREADY = 1'b0;
        aw_ready_after = AWREADY;
    endtask

    task automatic axi_read(input logic [19:0] addr, input logic [7:0] len, input logic [0:0] id);
        int k;
        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        k = 0;
        while (ARREADY !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
        if (k >= 50) begin timeout("ar"); ARVALID = 1'b0; return; end
        @(negedge ACLK);
        ARVALID = 1'b0;
        r_first = RVALID;
        for (int i = 0; i <= int'(len); i++) begin
            if (gap_en != 0 && $urandom_range(0, 3) == 0) begin RREADY = 1'b0; @(negedge ACLK); end
            k = 0;
            while (RVALID !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
            if (k >= 50) begin timeout("r"); return; end
            rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id[i] = RID;
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0;
        end
        ar_ready_after = ARREADY;
    endtask

    task automatic test_reset();
        AWID = 0; AWADDR = 0; AWLEN = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0;
        BREADY = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        ARESETN = 1'b1;
        #2 ARESETN = 1'b0;
        #1;
        n_checks++;
        if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
        end
        n_checks++;
        if ({BID, BRESP, RID, RRESP, RDATA} !== 38'h0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0", {BID, BRESP, RID, RRESP, RDATA});
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        n_checks++;
        if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_early: got aw=%b ar=%b required 0 0", AWREADY, ARREADY);
        end
        @(posedge ACLK); #1;
        n_checks++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got aw=%b ar=%b required 1 1", AWREADY, ARREADY);
        end
    endtask

    task automatic test_incr_burst();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3); end
        axi_write(20'h8, 8'd3, 1'b1);
        exp = model_write(20'h8, 3);
        n_checks++;
        if (b_resp !== 2'b00 || exp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp: got %b required 00", b_resp); end
        n_checks++;
        if (b_first !== 1'b1) begin n_fail++; $display("FAIL incr_b_latency: got bvalid=%b required 1", b_first); end
        n_checks++;
        if (b_id !== 1'b1) begin n_fail++; $display("FAIL incr_bid: got %b required 1", b_id); end
        n_checks++;
        if (aw_ready_after !== 1'b1) begin n_fail++; $display("FAIL incr_awready_after: got %b required 1", aw_ready_after); end
        axi_read(20'h8, 8'd3, 1'b0);
        n_checks++;
        if (r_first !== 1'b1) begin n_fail++; $display("FAIL incr_r_latency: got rvalid=%b required 1", r_first); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00 || rd_id[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL incr_read beat %0d: got data=%h last=%b resp=%b id=%b required data=%h last=%b resp=00 id=0",
                         i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], i + 1, i == 3);
            end
        end
        n_checks++;
        if (ar_ready_after !== 1'b1) begin n_fail++; $display("FAIL incr_arready_after: got %b required 1", ar_ready_after); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp;
        wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 0; wl[1] = 1;
        axi_write(20'h3C, 8'd1, 1'b0);
        exp = model_write(20'h3C, 1);
        n_checks++;
        if (b_resp !== exp) begin n_fail++; $display("FAIL wrap_bresp: got %b required %b", b_resp, exp); end
        axi_read(20'h3C, 8'd1, 1'b1);
        n_checks++;
        if (rd_data[0] !== 32'hA || rd_data[1] !== 32'hB || rd_last[1] !== 1'b1 || rd_id[0] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_read: got %h %h last=%b required a b last=1", rd_data[0], rd_data[1], rd_last[1]);
        end
        axi_read(20'h0, 8'd0, 1'b0);
        n_checks++;
        if (rd_data[0] !== 32'hB) begin n_fail++; $display("FAIL wrap_word0: got %h required b", rd_data[0]); end
    endtask

    task automatic test_strobe();
        logic [1:0] exp;
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF; wl[0] = 1;
        axi_write(20'h8, 8'd0, 1'b0);
        exp = model_write(20'h8, 0);
        wd[0] = 32'h0; ws[0] = 4'h5;
        axi_write(20'h8, 8'd0, 1'b0);
        exp = model_write(20'h8, 0);
        axi_read(20'h8, 8'd0, 1'b0);
        n_checks++;
        if (rd_data[0] !== 32'hFF00_FF00 || model[2] !== 32'hFF00_FF00) begin
            n_fail++; $display("FAIL strobe_read: got %h required ff00ff00", rd_data[0]);
        end
    endtask

    task automatic test_decerr();
        logic [1:0] exp;
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; wl[0] = 1;
        axi_write(20'h40, 8'd0, 1'b1);
        exp = model_write(20'h40, 0);
        n_checks++;
        if (b_resp !== 2'b11 || exp !== 2'b11) begin n_fail++; $display("FAIL decerr_bresp: got %b required 11", b_resp); end
        axi_read(20'h0, 8'd0, 1'b0);
        n_checks++;
        if (rd_data[0] !== exp_rdata(20'h0, 0)) begin
            n_fail++; $display("FAIL decerr_mem_unchanged: got %h required %h", rd_data[0], exp_rdata(20'h0, 0));
        end
        axi_read(20'h40, 8'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b11 || rd_last[i] !== (i == 1)) begin
                n_fail++; $display("FAIL decerr_read beat %0d: got data=%h resp=%b last=%b required 0 11 %b",
                                   i, rd_data[i], rd_resp[i], rd_last[i], i == 1);
            end
        end
    endtask

    task automatic test_slverr_and_hold();
        logic [1:0]  exp;
        logic [31:0] old_v;
        int          k;
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h100 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 1); end
        axi_write(20'h10, 8'd2, 1'b0);
        exp = model_write(20'h10, 2);
        n_checks++;
        if (b_resp !== 2'b10 || exp !== 2'b10) begin n_fail++; $display("FAIL slverr_bresp: got %b required 10", b_resp); end
        axi_read(20'h10, 8'd2, 1'b0);
        n_checks++;
        if (rd_data[0] !== 32'h100 || rd_data[1] !== 32'h101 || rd_data[2] !== 32'h102) begin
            n_fail++; $display("FAIL slverr_writes: got %h %h %h required 100 101 102", rd_data[0], rd_data[1], rd_data[2]);
        end
        wd[0] = 32'h1234_5678; ws[0] = 4'hF; wl[0] = 1;
        axi_write(20'h14, 8'd0, 1'b0);
        exp = model_write(20'h14, 0);
        old_v = model[5];
        fork
            begin
                @(negedge ACLK);
                ARID = 1'b1; ARADDR = 20'h14; ARLEN = 8'd0; ARVALID = 1'b1;
                k = 0;
                while (ARREADY !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
                if (k >= 50) timeout("hold_ar");
                @(negedge ACLK);
                ARVALID = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    n_checks++;
                    if (RVALID !== 1'b1 || RDATA !== old_v || RLAST !== 1'b1 || RRESP !== 2'b00) begin
                        n_fail++; $display("FAIL hold_stall cycle %0d: got valid=%b data=%h last=%b required 1 %h 1",
                                           c, RVALID, RDATA, RLAST, old_v);
                    end
                    @(negedge ACLK);
                end
                RREADY = 1'b1;
                @(negedge ACLK);
                RREADY = 1'b0;
            end
            begin
                @(negedge ACLK);
                wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF; wl[0] = 1;
                axi_write(20'h14, 8'd0, 1'b1);
            end
        join
        exp = model_write(20'h14, 0);
        axi_read(20'h14, 8'd0, 1'b0);
        n_checks++;
        if (rd_data[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hold_after_write: got %h required cafef00d", rd_data[0]); end
    endtask

    task automatic test_random();
        logic [19:0] addr;
        logic [7:0]  len;
        logic [0:0]  id;
        logic [1:0]  exp;
        gap_en = 1;
        for (int t = 0; t < 30; t++) begin
            addr = 20'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) addr = addr | 20'(64 << $urandom_range(0, 13));
            len = 8'($urandom_range(0, 5));
            id  = 1'($urandom_range(0, 1));
            for (int i = 0; i <= int'(len); i++) begin
                wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
                wl[i] = ($urandom_range(0, 9) == 0) ? (i != int'(len)) : (i == int'(len));
            end
            axi_write(addr, len, id);
            exp = model_write(addr, int'(len));
            n_checks++;
            if (b_resp !== exp || b_id !== id || aw_ready_after !== 1'b1) begin
                n_fail++; $display("FAIL rand_write %0d: got resp=%b id=%b awready=%b required %b %b 1",
                                   t, b_resp, b_id, aw_ready_after, exp, id);
            end
            addr = 20'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) addr = addr | 20'h40;
            len = 8'($urandom_range(0, 5));
            id  = 1'($urandom_range(0, 1));
            axi_read(addr, len, id);
            for (int i = 0; i <= int'(len); i++) begin
                n_checks++;
                if (rd_data[i] !== exp_rdata(addr, i) || rd_resp[i] !== exp_rresp(addr) ||
                    rd_last[i] !== (i == int'(len)) || rd_id[i] !== id) begin
                    n_fail++; $display("FAIL rand_read %0d beat %0d: got data=%h resp=%b last=%b id=%b required %h %b %b %b",
                                       t, i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i],
                                       exp_rdata(addr, i), exp_rresp(addr), i == int'(len), id);
                end
            end
        end
        gap_en = 0;
    endtask

    task automatic test_reset_mid_read();
        int k;
        @(negedge ACLK);
        ARID = 1'b0; ARADDR = 20'h0; ARLEN = 8'd3; ARVALID = 1'b1;
        k = 0;
        while (ARREADY !== 1'b1 && k < 50) begin @(negedge ACLK); k++; end
        if (k >= 50) timeout("rst_ar");
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        ARESETN = 1'b0;
        #1;
        n_checks++;
        if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_read: got rvalid=%b rlast=%b rdata=%h arready=%b required 0 0 0 0",
                               RVALID, RLAST, RDATA, ARREADY);
        end
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        n_checks++;
        if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL rst_arready: got %b required 1", ARREADY); end
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            n_checks++;
            if (RVALID !== 1'b0 || BVALID !== 1'b0) begin
                n_fail++; $display("FAIL rst_stale cycle %0d: got rvalid=%b bvalid=%b required 0 0", c, RVALID, BVALID);
            end
        end
        RREADY = 1'b0;
        axi_read(20'h8, 8'd1, 1'b0);
        n_checks++;
        if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0) begin
            n_fail++; $display("FAIL rst_mem_clear: got %h %h required 0 0", rd_data[0], rd_data[1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_incr_burst();
        test_wrap();
        test_strobe();
        test_decerr();
        test_slverr_and_hold();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
